// File: rtl/adc_pkg.sv
// Shared definitions for the serial ADC sampler.
//   ADC_BITS_DEF : default conversion frame width (= adc_data width)
//   adc_state_e  : sequencing FSM encoding (IDLE/SETUP/SHIFT/GAP)
package adc_pkg;

    localparam int ADC_BITS_DEF = 16;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_SETUP_ENC = 2'd1;
    localparam logic [1:0] ST_SHIFT_ENC = 2'd2;
    localparam logic [1:0] ST_GAP_ENC   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_SETUP = ST_SETUP_ENC,
        ST_SHIFT = ST_SHIFT_ENC,
        ST_GAP   = ST_GAP_ENC
    } adc_state_e;

endpackage

// File: rtl/adc_sclk_div.sv
// Serial clock generator for the ADC interface.
// A down-counter times each sclk half-period; on terminal count the sclk
// level toggles and a one-cycle strobe marks the edge about to happen.
// Ports:
//   clk        in  system clock
//   rst        in  synchronous active-high reset
//   run        in  1 = generate sclk; 0 = hold sclk low, counter reloaded
//   sclk       out serial clock level (registered, idles low)
//   sclk_rise  out high in the cycle whose closing edge drives sclk 0->1
//   sclk_fall  out high in the cycle whose closing edge drives sclk 1->0
module adc_sclk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic sclk,
    output logic sclk_rise,
    output logic sclk_fall
);

    localparam int CW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sclk_q, sclk_d;
    logic          tc;

    assign tc = (cnt_q == '0);

    always_comb begin
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        if (!run) begin
            cnt_d  = RELOAD;
            sclk_d = 1'b0;
        end else if (tc) begin
            cnt_d  = RELOAD;
            sclk_d = ~sclk_q;
        end else begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= RELOAD;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk      = sclk_q;
    assign sclk_rise = run & tc & ~sclk_q;
    assign sclk_fall = run & tc &  sclk_q;

endmodule

// File: rtl/adc_serial_sampler.sv
// Serial ADC sampler: runs back-to-back SPI-style conversions, averages
// 2**AVG_LOG2 frames and hands the result to the temperature datapath.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | cs_n high, sclk low, accumulator cleared; waits for en
// SETUP | cs_n low for CLK_DIV cycles before the first sclk edge
// SHIFT | ADC_BITS sclk periods, sdo captured on each rising edge
// GAP   | cs_n high for CONV_GAP cycles; result lands on entry
//
// Ports:
//   clk        in  system clock
//   rst        in  synchronous active-high reset
//   en         in  1 = convert continuously
//   adc_cs_n   out ADC chip select, active low
//   adc_sclk   out ADC serial clock, idles low
//   adc_sdo    in  ADC serial data, MSB first
//   adc_data   out averaged result
//   adc_valid  out adc_data holds an unconsumed result
//   adc_ready  in  consumer accepts (transfer = valid & ready)
//   overrun    out sticky: an unconsumed result was overwritten
module adc_serial_sampler
    import adc_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int ADC_BITS = ADC_BITS_DEF,
    parameter int AVG_LOG2 = 2,
    parameter int CONV_GAP = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    output logic                adc_cs_n,
    output logic                adc_sclk,
    input  logic                adc_sdo,
    output logic [ADC_BITS-1:0] adc_data,
    output logic                adc_valid,
    input  logic                adc_ready,
    output logic                overrun
);

    localparam int ACC_W = ADC_BITS + AVG_LOG2;
    localparam int CNV_W = AVG_LOG2 + 1;
    localparam int BIT_W = $clog2(ADC_BITS);
    localparam int TMR_W = $clog2(((CLK_DIV > CONV_GAP) ? CLK_DIV : CONV_GAP) + 1);

    localparam logic [CNV_W-1:0] CNV_LAST  = CNV_W'((1 << AVG_LOG2) - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(ADC_BITS - 1);
    localparam logic [TMR_W-1:0] TMR_SETUP = TMR_W'(CLK_DIV - 1);
    localparam logic [TMR_W-1:0] TMR_GAP   = TMR_W'(CONV_GAP - 1);

    adc_state_e          state_q, state_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [ADC_BITS-1:0] shift_q, shift_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [CNV_W-1:0]    cnv_q, cnv_d;
    logic                drop_q, drop_d;
    logic [ADC_BITS-1:0] data_q, data_d;
    logic                valid_q, valid_d;
    logic                overrun_q, overrun_d;
    logic                cs_n_q, cs_n_d;

    logic                sclk_rise, sclk_fall;
    logic [ACC_W-1:0]    acc_sum;

    adc_sclk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_div (
        .clk       (clk),
        .rst       (rst),
        .run       (state_q == ST_SHIFT),
        .sclk      (adc_sclk),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall)
    );

    // Accumulator is wide enough for 2**AVG_LOG2 full-scale words.
    assign acc_sum = acc_q + ACC_W'(shift_q);

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        acc_d     = acc_q;
        cnv_d     = cnv_q;
        drop_d    = drop_q;
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        if (valid_q && adc_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                acc_d  = '0;
                cnv_d  = CNV_LAST;
                drop_d = 1'b0;
                if (en) begin
                    state_d = ST_SETUP;
                    tmr_d   = TMR_SETUP;
                end
            end
            ST_SETUP: begin
                if (!en) begin
                    drop_d = 1'b1;
                end
                if (tmr_q == '0) begin
                    state_d = ST_SHIFT;
                    bit_d   = BIT_LAST;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            ST_SHIFT: begin
                // Any en drop during the frame marks it for discard; the
                // frame itself still runs to completion on the pins.
                if (!en) begin
                    drop_d = 1'b1;
                end
                if (sclk_rise) begin
                    shift_d = {shift_q[ADC_BITS-2:0], adc_sdo};
                end
                if (sclk_fall) begin
                    if (bit_q == '0) begin
                        state_d = ST_GAP;
                        tmr_d   = TMR_GAP;
                        if (drop_q || !en) begin
                            acc_d = '0;
                            cnv_d = CNV_LAST;
                        end else if (cnv_q == '0) begin
                            data_d  = acc_sum[ACC_W-1:AVG_LOG2];
                            valid_d = 1'b1;
                            if (valid_q && !adc_ready) begin
                                overrun_d = 1'b1;
                            end
                            acc_d = '0;
                            cnv_d = CNV_LAST;
                        end else begin
                            acc_d = acc_sum;
                            cnv_d = cnv_q - CNV_W'(1);
                        end
                    end else begin
                        bit_d = bit_q - BIT_W'(1);
                    end
                end
            end
            ST_GAP: begin
                if (tmr_q == '0) begin
                    drop_d = 1'b0;
                    if (en) begin
                        state_d = ST_SETUP;
                        tmr_d   = TMR_SETUP;
                    end else begin
                        state_d = ST_IDLE;
                        acc_d   = '0;
                        cnv_d   = CNV_LAST;
                    end
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Chip select is registered from the next state so it moves on the
        // same edge as the FSM and never glitches.
        cs_n_d = !((state_d == ST_SETUP) || (state_d == ST_SHIFT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            tmr_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            acc_q     <= '0;
            cnv_q     <= CNV_LAST;
            drop_q    <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            cs_n_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            acc_q     <= acc_d;
            cnv_q     <= cnv_d;
            drop_q    <= drop_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            cs_n_q    <= cs_n_d;
        end
    end

    assign adc_cs_n  = cs_n_q;
    assign adc_data  = data_q;
    assign adc_valid = valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_adc_serial_sampler.sv
module tb_adc_serial_sampler;

    localparam int CLK_DIV  = 4;
    localparam int ADC_BITS = 16;
    localparam int CONV_GAP = 8;
    localparam int LOW_WIN  = CLK_DIV * (1 + 2 * ADC_BITS);
    localparam int PERIOD   = LOW_WIN + CONV_GAP;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        en0 = 1'b0, ready0 = 1'b1, sdo0 = 1'b0;
    logic        cs_n0, sclk0, valid0, ovr0;
    logic [15:0] data0;

    logic        en2 = 1'b0, ready2 = 1'b1, sdo2 = 1'b0;
    logic        cs_n2, sclk2, valid2, ovr2;
    logic [15:0] data2;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    logic [15:0] words0 [0:7];
    logic [15:0] words2 [0:31];
    logic [15:0] cur0 = '0, cur2 = '0;
    int fidx0 = 0, fidx2 = 0, bitp0 = 0, bitp2 = 0;
    int rises0 = 0, rises2 = 0, starts0 = 0, starts2 = 0;
    int fall_cyc0 = 0, fall_cyc2 = 0;
    logic cs_p0 = 1'b1, sclk_p0 = 1'b0, cs_p2 = 1'b1, sclk_p2 = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adc_serial_sampler #(
        .CLK_DIV (CLK_DIV), .ADC_BITS (ADC_BITS), .AVG_LOG2 (0), .CONV_GAP (CONV_GAP)
    ) dut0 (
        .clk (clk), .rst (rst), .en (en0),
        .adc_cs_n (cs_n0), .adc_sclk (sclk0), .adc_sdo (sdo0),
        .adc_data (data0), .adc_valid (valid0), .adc_ready (ready0),
        .overrun (ovr0)
    );

    adc_serial_sampler #(
        .CLK_DIV (CLK_DIV), .ADC_BITS (ADC_BITS), .AVG_LOG2 (2), .CONV_GAP (CONV_GAP)
    ) dut2 (
        .clk (clk), .rst (rst), .en (en2),
        .adc_cs_n (cs_n2), .adc_sclk (sclk2), .adc_sdo (sdo2),
        .adc_data (data2), .adc_valid (valid2), .adc_ready (ready2),
        .overrun (ovr2)
    );

    // ADC models: load the next programmed word when cs_n falls (MSB out
    // immediately), advance one bit on each sclk fall. Also count sclk rises
    // per cs_n low window.
    always @(negedge clk) begin
        if (cs_p0 && !cs_n0) begin
            cur0      = words0[fidx0 % 8];
            fidx0     = fidx0 + 1;
            bitp0     = ADC_BITS - 1;
            sdo0      = cur0[bitp0];
            rises0    = 0;
            starts0   = starts0 + 1;
            fall_cyc0 = cyc;
        end else if (!cs_n0 && sclk_p0 && !sclk0) begin
            if (bitp0 > 0) bitp0 = bitp0 - 1;
            sdo0 = cur0[bitp0];
        end
        if (!cs_n0 && !sclk_p0 && sclk0) rises0 = rises0 + 1;
        cs_p0   = cs_n0;
        sclk_p0 = sclk0;
    end

    always @(negedge clk) begin
        if (cs_p2 && !cs_n2) begin
            cur2      = words2[fidx2 % 32];
            fidx2     = fidx2 + 1;
            bitp2     = ADC_BITS - 1;
            sdo2      = cur2[bitp2];
            rises2    = 0;
            starts2   = starts2 + 1;
            fall_cyc2 = cyc;
        end else if (!cs_n2 && sclk_p2 && !sclk2) begin
            if (bitp2 > 0) bitp2 = bitp2 - 1;
            sdo2 = cur2[bitp2];
        end
        if (!cs_n2 && !sclk_p2 && sclk2) rises2 = rises2 + 1;
        cs_p2   = cs_n2;
        sclk_p2 = sclk2;
    end

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_miss = n_miss + 1;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic cs_of(input int sel);
        return (sel == 0) ? cs_n0 : cs_n2;
    endfunction

    function automatic int rises_of(input int sel);
        return (sel == 0) ? rises0 : rises2;
    endfunction

    // Returns on the first sample where cs_n has just gone high.
    task automatic wait_frame_end(input int sel, input string tag);
        logic prev;
        logic seen;
        seen = 1'b0;
        prev = cs_of(sel);
        for (int i = 0; i < 400 && !seen; i++) begin
            tick(1);
            if (!prev && cs_of(sel)) seen = 1'b1;
            prev = cs_of(sel);
        end
        chk_val(tag, 32'(seen), 32'd1);
    endtask

    task automatic wait_rises(input int sel, input int n, input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            tick(1);
            if (rises_of(sel) == n) seen = 1'b1;
        end
        chk_val(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        int t0, t1, t2, st;

        for (int i = 0; i < 8; i++) words0[i] = 16'hAAAA;
        words0[2] = 16'h1234;
        words0[3] = 16'h5678;

        for (int i = 0; i < 32; i++) words2[i] = 16'h0000;
        words2[0] = 16'h0001; words2[1] = 16'h0002;
        words2[2] = 16'h0003; words2[3] = 16'h0004;
        for (int i = 4; i < 8; i++)  words2[i] = 16'hFFFF;
        for (int i = 8; i < 12; i++) words2[i] = 16'h1111;
        for (int i = 12; i < 16; i++) words2[i] = 16'h2222;
        words2[16] = 16'h0400; words2[17] = 16'h0800;
        words2[18] = 16'h0010; words2[19] = 16'h0020;
        words2[20] = 16'h0030; words2[21] = 16'h0040;
        words2[22] = 16'h4000; words2[23] = 16'hFFFF;
        words2[24] = 16'h0100; words2[25] = 16'h0200;
        words2[26] = 16'h0300; words2[27] = 16'h0500;

        // reset state
        tick(3);
        chk_val("rst_cs0",    32'(cs_n0),  32'd1);
        chk_val("rst_sclk0",  32'(sclk0),  32'd0);
        chk_val("rst_valid0", 32'(valid0), 32'd0);
        chk_val("rst_data0",  32'(data0),  32'h0);
        chk_val("rst_ovr0",   32'(ovr0),   32'd0);
        chk_val("rst_cs2",    32'(cs_n2),  32'd1);
        chk_val("rst_valid2", 32'(valid2), 32'd0);
        rst = 1'b0;

        // single-conversion instance: frame shape, data, period
        en0 = 1'b1;
        wait_frame_end(0, "t1_end0");
        t0 = cyc;
        chk_val("t1_valid",   32'(valid0), 32'd1);
        chk_val("t1_data",    32'(data0),  32'hAAAA);
        chk_val("t1_rises",   32'(rises0), 32'd16);
        chk_val("t1_low_win", 32'(cyc - fall_cyc0), 32'(LOW_WIN));
        tick(1);
        chk_val("t1_consumed", 32'(valid0), 32'd0);
        wait_frame_end(0, "t1_end1");
        t1 = cyc;
        chk_val("t1_period", 32'(t1 - t0), 32'(PERIOD));
        chk_val("t1_data1",  32'(data0),  32'hAAAA);
        chk_val("t1_rises1", 32'(rises0), 32'd16);
        tick(1);
        chk_val("t1_consumed1", 32'(valid0), 32'd0);
        ready0 = 1'b0;

        // ready pulsed in the cycle a new result lands
        wait_frame_end(0, "t4_end2");
        t2 = cyc;
        chk_val("t4_data_a",  32'(data0),  32'h1234);
        chk_val("t4_valid_a", 32'(valid0), 32'd1);
        tick(PERIOD - 1);
        chk_val("t4_cs_pre",     32'(cs_n0),  32'd0);
        chk_val("t4_data_hold",  32'(data0),  32'h1234);
        chk_val("t4_valid_hold", 32'(valid0), 32'd1);
        ready0 = 1'b1;
        tick(1);
        ready0 = 1'b0;
        chk_val("t4_cs_rise",  32'(cs_n0),  32'd1);
        chk_val("t4_time",     32'(cyc - t2), 32'(PERIOD));
        chk_val("t4_data_b",   32'(data0),  32'h5678);
        chk_val("t4_valid_b",  32'(valid0), 32'd1);
        chk_val("t4_ovr",      32'(ovr0),   32'd0);
        tick(1);
        chk_val("t4_valid_kept", 32'(valid0), 32'd1);
        en0    = 1'b0;
        ready0 = 1'b1;
        tick(1);
        chk_val("t4_valid_done", 32'(valid0), 32'd0);

        // averaging instance
        en2 = 1'b1;
        repeat (4) wait_frame_end(2, "t2_end");
        chk_val("t2_avg_1234", 32'(data2),  32'h0002);
        chk_val("t2_valid",    32'(valid2), 32'd1);
        repeat (4) wait_frame_end(2, "t2_end");
        chk_val("t2_avg_ffff", 32'(data2),  32'hFFFF);
        chk_val("t2_valid_f",  32'(valid2), 32'd1);
        tick(1);
        chk_val("t2_consumed", 32'(valid2), 32'd0);
        ready2 = 1'b0;

        // overrun
        repeat (4) wait_frame_end(2, "t3_end");
        chk_val("t3_data_1111", 32'(data2),  32'h1111);
        chk_val("t3_valid_1",   32'(valid2), 32'd1);
        chk_val("t3_ovr_0",     32'(ovr2),   32'd0);
        repeat (4) wait_frame_end(2, "t3_end");
        chk_val("t3_data_2222", 32'(data2),  32'h2222);
        chk_val("t3_valid_2",   32'(valid2), 32'd1);
        chk_val("t3_ovr_1",     32'(ovr2),   32'd1);
        ready2 = 1'b1;
        tick(1);
        chk_val("t3_valid_clr", 32'(valid2), 32'd0);
        chk_val("t3_ovr_stick", 32'(ovr2),   32'd1);

        // en dropped mid-frame: frame finishes, partial group discarded
        wait_frame_end(2, "t5_end16");
        wait_rises(2, 8, "t5_bit8");
        en2 = 1'b0;
        wait_frame_end(2, "t5_end17");
        chk_val("t5_rises", 32'(rises2), 32'd16);
        chk_val("t5_valid", 32'(valid2), 32'd0);
        st = starts2;
        tick(30);
        chk_val("t5_idle_cs",    32'(cs_n2),   32'd1);
        chk_val("t5_idle_sclk",  32'(sclk2),   32'd0);
        chk_val("t5_idle_valid", 32'(valid2),  32'd0);
        chk_val("t5_no_frame",   32'(starts2), 32'(st));
        en2 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_frame_end(2, "t5_regroup");
            chk_val("t5_no_early", 32'(valid2), 32'd0);
        end
        wait_frame_end(2, "t5_regroup");
        chk_val("t5_avg",   32'(data2),  32'h0028);
        chk_val("t5_valid1", 32'(valid2), 32'd1);

        // reset mid-SHIFT, second frame of a group
        wait_frame_end(2, "t6_end22");
        wait_rises(2, 5, "t6_bit5");
        rst = 1'b1;
        tick(1);
        chk_val("t6_cs",    32'(cs_n2),  32'd1);
        chk_val("t6_sclk",  32'(sclk2),  32'd0);
        chk_val("t6_data",  32'(data2),  32'h0);
        chk_val("t6_valid", 32'(valid2), 32'd0);
        chk_val("t6_ovr",   32'(ovr2),   32'd0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_frame_end(2, "t6_regroup");
            chk_val("t6_no_early", 32'(valid2), 32'd0);
        end
        wait_frame_end(2, "t6_regroup");
        chk_val("t6_avg",    32'(data2),  32'h02C0);
        chk_val("t6_valid1", 32'(valid2), 32'd1);
        chk_val("t6_ovr1",   32'(ovr2),   32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
